// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, ALU, PC/branch unit and a req/ack memory port.
// One instruction in flight at a time: IDLE -> EXEC -> (MEM) -> WB -> IDLE.
module datapath_mc #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      NREGS    = 32,
    parameter int unsigned      ADDR_W   = 10,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter bit               ZERO_REG = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [4:0]                alucode,
    input  logic [$clog2(NREGS)-1:0]  op1,
    input  logic [$clog2(NREGS)-1:0]  op2,
    input  logic [$clog2(NREGS)-1:0]  op3,
    input  logic [WIDTH-1:0]          imm,
    input  logic                      imControl,
    input  logic                      regenable,
    input  logic                      memread,
    input  logic                      memwrite,
    input  logic [2:0]                pcControl,
    input  logic [1:0]                writecode,
    output logic                      ready,
    output logic                      done,
    output logic                      div0,
    output logic [WIDTH-1:0]          PC,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WIDTH-1:0]          mem_wdata,
    input  logic                      mem_ack,
    input  logic [WIDTH-1:0]          mem_rdata
);
    localparam int unsigned RW = $clog2(NREGS);
    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] regs [NREGS];

    logic [4:0]       alucode_q;
    logic [RW-1:0]    op1_q;
    logic             regen_q, memread_q, memwrite_q, div0_q;
    logic [2:0]       pcc_q;
    logic [1:0]       wc_q;
    logic [WIDTH-1:0] a_q, b_q, c_q, result_q, jump_q, rdata_q;

    logic [WIDTH-1:0] alu, jump, wb_val;
    logic             div_zero, taken;
    logic [SW-1:0]    sh;

    function automatic logic [WIDTH-1:0] rd(input logic [RW-1:0] idx);
        return (ZERO_REG && idx == '0) ? '0 : regs[idx];
    endfunction

    assign ready = (state == IDLE);
    assign sh    = b_q[SW-1:0];

    // ALU over the latched operands; divide/modulo by zero saturate to all ones.
    always_comb begin
        alu      = '1;
        div_zero = 1'b0;
        case (alucode_q)
            5'd0:  alu = a_q;
            5'd1:  alu = a_q + b_q;
            5'd2:  alu = a_q - b_q;
            5'd3:  alu = a_q * b_q;
            5'd4:  if (b_q == '0) div_zero = 1'b1; else alu = a_q / b_q;
            5'd5:  if (b_q == '0) div_zero = 1'b1; else alu = a_q % b_q;
            5'd6:  alu = a_q | b_q;
            5'd7:  alu = a_q & b_q;
            5'd8:  alu = a_q ^ b_q;
            5'd9:  alu = ~a_q;
            5'd10: alu = a_q >> 1;
            5'd11: alu = a_q << 1;
            5'd12: alu = a_q >> sh;
            5'd13: alu = a_q << sh;
            5'd14: alu = $signed(a_q) >>> sh;
            default: alu = '1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (pcc_q)
            3'd1: taken = (a_q == b_q);
            3'd2: taken = (a_q <  b_q);
            3'd3: taken = (a_q >  b_q);
            3'd4: taken = (a_q != b_q);
            3'd5: taken = (a_q <= b_q);
            3'd6: taken = (a_q >= b_q);
            default: taken = 1'b0;
        endcase
        jump = (pcc_q == 3'd7 || taken) ? c_q : WIDTH'(1);
    end

    always_comb begin
        wb_val = result_q;
        case (wc_q)
            2'd0: wb_val = result_q;
            2'd1: wb_val = b_q;
            2'd2: wb_val = rdata_q;
            2'd3: wb_val = PC + WIDTH'(1);
            default: wb_val = result_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = EXEC;
            EXEC: state_next = (memread_q || memwrite_q) ? MEM : WB;
            MEM:  if (mem_ack) state_next = WB;
            WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the register file is reset like any other state here, so it maps to flops, not RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
            PC         <= PC_RESET;
            done       <= 1'b0;
            div0       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            alucode_q  <= '0;
            op1_q      <= '0;
            regen_q    <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            pcc_q      <= '0;
            wc_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            result_q   <= '0;
            jump_q     <= '0;
            rdata_q    <= '0;
            div0_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    alucode_q  <= alucode;
                    op1_q      <= op1;
                    regen_q    <= regenable;
                    memread_q  <= memread;
                    memwrite_q <= memwrite;
                    pcc_q      <= pcControl;
                    wc_q       <= writecode;
                    a_q        <= rd(op1);
                    b_q        <= imControl ? imm : rd(op2);
                    c_q        <= rd(op3);
                end
                EXEC: begin
                    result_q <= alu;
                    jump_q   <= jump;
                    div0_q   <= div_zero;
                    if (memread_q || memwrite_q) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memwrite_q && !memread_q;
                        mem_addr  <= alu[ADDR_W-1:0];
                        mem_wdata <= c_q;
                    end
                end
                MEM: if (mem_ack) begin
                    rdata_q <= mem_rdata;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                WB: begin
                    done <= 1'b1;
                    div0 <= div0_q;
                    if (regen_q && !(ZERO_REG && op1_q == '0)) regs[op1_q] <= wb_val;
                    PC <= PC + jump_q;
                end
                default: ;
            endcase
        end
    end
endmodule
